din_serializer: RTL and testbench

Parallel-to-serial stage that feeds the serial sequence detectors (`xulie_*`) their `Din` bit stream. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on `Dout`, with a bit-valid strobe. It supports gapless back-to-back words, so patterns that span word boundaries reach the detector intact.

---
 rtl/ser_pkg.sv | 12 +
 rtl/din_serializer_if.sv | 12 +
 rtl/ser_bit_counter.sv | 20 ++
 rtl/din_serializer.sv | 109 ++++++++++
 tb/tb_din_serializer.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/ser_pkg.sv
// ser_pkg: one-hot state encoding, state width and parity helper shared by din_serializer
package ser_pkg;
    localparam int ST_W = 3;
    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 3'b001,
        ST_SHIFT = 3'b010,
        ST_PAR   = 3'b100
    } state_t;
    function automatic logic even_par(input logic [63:0] w);
        return ^w;
    endfunction
endpackage

// File: rtl/din_serializer_if.sv
// din_serializer_if: word handshake and serial output bundle for din_serializer
interface din_serializer_if #(parameter int WIDTH = 8);
    logic             Load;
    logic [WIDTH-1:0] Pdata;
    logic             Ready;
    logic             Dout;
    logic             Dvalid;
    logic             Last;
    logic             Busy;
    modport master (output Load, Pdata, input Ready, Dout, Dvalid, Last, Busy);
    modport slave  (input Load, Pdata, output Ready, Dout, Dvalid, Last, Busy);
endinterface

// File: rtl/ser_bit_counter.sv
// ser_bit_counter: clear/enable bit counter flagging terminal count at WIDTH-1
module ser_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(WIDTH);
    logic [CW-1:0] cnt_q, cnt_d;
    // clear takes priority over counting
    always_comb cnt_d = clr ? '0 : en ? cnt_q + CW'(1) : cnt_q;
    // count register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign tc = cnt_q == CW'(WIDTH - 1);
endmodule

// File: rtl/din_serializer.sv
// din_serializer: WIDTH-bit word to serial Dout with Dvalid/Last strobes; SER_PARITY_EN appends an even-parity bit
module din_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_LVL  = 1'b0
) (
    input logic              Clk,
    input logic              Reset_n,
    din_serializer_if.slave  bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d, sh_nxt;
    logic             dout_q, dout_d, dvalid_q, dvalid_d;
    logic             cnt_clr, cnt_en, tc, accept;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif

    ser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (Clk),
        .rst_n (Reset_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (tc)
    );

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

`ifdef SER_PARITY_EN
    assign bus.Ready = state_q == ST_IDLE || state_q == ST_PAR;
    assign bus.Last  = state_q == ST_PAR;
`else
    assign bus.Ready = state_q == ST_IDLE || (state_q == ST_SHIFT && tc);
    assign bus.Last  = state_q == ST_SHIFT && tc;
`endif
    assign accept  = bus.Load && bus.Ready;
    assign sh_nxt  = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
    assign bus.Dout   = dout_q;
    assign bus.Dvalid = dvalid_q;
    assign bus.Busy   = dvalid_q;

    // next state, next shift contents and next registered serial outputs
    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        dout_d   = IDLE_LVL;
        dvalid_d = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
`ifdef SER_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_SHIFT:
                if (!tc) begin
                    cnt_en   = 1'b1;
                    sh_d     = sh_nxt;
                    dout_d   = head(sh_nxt);
                    dvalid_d = 1'b1;
                end
`ifdef SER_PARITY_EN
                else begin
                    state_d  = ST_PAR;
                    dout_d   = par_q;
                    dvalid_d = 1'b1;
                end
            ST_PAR: state_d = ST_IDLE;
`else
                else state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            state_d  = ST_SHIFT;
            sh_d     = bus.Pdata;
            dout_d   = head(bus.Pdata);
            dvalid_d = 1'b1;
            cnt_clr  = 1'b1;
`ifdef SER_PARITY_EN
            par_d    = even_par(64'(bus.Pdata));
`endif
        end
    end

    // state, shift register and registered outputs; reset discards any partial frame
    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            sh_q     <= '0;
            dout_q   <= IDLE_LVL;
            dvalid_q <= 1'b0;
`ifdef SER_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
`ifdef SER_PARITY_EN
            par_q    <= par_d;
`endif
        end
endmodule

// File: tb/tb_din_serializer.sv
// tb_din_serializer: MSB-first and LSB-first serializers against a bit-queue reference model
module tb_din_serializer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    din_serializer_if #(.WIDTH(8)) b0 ();
    din_serializer_if #(.WIDTH(8)) b1 ();

    din_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) dut0 (.Clk(clk), .Reset_n(rst_n), .bus(b0));
    din_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0)) dut1 (.Clk(clk), .Reset_n(rst_n), .bus(b1));

`ifdef SER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic [63:0] pb [2];
    logic [63:0] pl [2];
    int          pn [2];
    int          n_assert = 0;
    int          n_fail = 0;
    int          det_hits = 0;
    logic [3:0]  hist = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_model();
        for (int i = 0; i < 2; i++) begin
            pn[i] = 0;
            pb[i] = '0;
            pl[i] = '0;
        end
    endtask

    task automatic check_dut(input int id, input logic dout, input logic dv, input logic rdy, input logic lst, input logic bsy);
        logic act;
        act = pn[id] > 0;
        chk($sformatf("dut%0d_dout", id), 32'(dout), 32'(act ? pb[id][0] : 1'b0));
        chk($sformatf("dut%0d_dvalid", id), 32'(dv), 32'(act));
        chk($sformatf("dut%0d_ready", id), 32'(rdy), 32'(!act || pl[id][0]));
        chk($sformatf("dut%0d_last", id), 32'(lst), 32'(act && pl[id][0]));
        chk($sformatf("dut%0d_busy", id), 32'(bsy), 32'(act));
    endtask

    task automatic model_edge(input int id, input logic ld, input logic [7:0] pd);
        logic rdy, b;
        rdy = pn[id] == 0 || pl[id][0];
        if (pn[id] > 0) begin
            pb[id] = pb[id] >> 1;
            pl[id] = pl[id] >> 1;
            pn[id]--;
        end
        if (ld && rst_n && rdy) begin
            for (int i = 0; i < FL; i++) begin
                if (i < 8) b = (id == 0) ? pd[7-i] : pd[i];
                else b = ^pd;
                pb[id][pn[id]+i] = b;
                pl[id][pn[id]+i] = (i == FL - 1);
            end
            pn[id] += FL;
        end
    endtask

    task automatic step(input logic l0, input logic [7:0] p0, input logic l1, input logic [7:0] p1);
        b0.Load = l0;
        b0.Pdata = p0;
        b1.Load = l1;
        b1.Pdata = p1;
        @(negedge clk);
        if (!rst_n) clr_model();
        check_dut(0, b0.Dout, b0.Dvalid, b0.Ready, b0.Last, b0.Busy);
        check_dut(1, b1.Dout, b1.Dvalid, b1.Ready, b1.Last, b1.Busy);
        if (b0.Dvalid) begin
            if ({hist[2:0], b0.Dout} == 4'b1110) det_hits++;
            hist = {hist[2:0], b0.Dout};
        end
        model_edge(0, l0, p0);
        model_edge(1, l1, p1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        b0.Load = 1'b0;
        b0.Pdata = '0;
        b1.Load = 1'b0;
        b1.Pdata = '0;
        clr_model();
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) step(1'(i % 2), 8'($urandom), 1'(i % 2), 8'($urandom));
        rst_n = 1'b1;
        repeat (2) step(1'b0, 8'h00, 1'b0, 8'h00);

        det_hits = 0;
        hist = '0;
        step(1'b1, 8'hEE, 1'b1, 8'h01);
        repeat (FL + 2) step(1'b0, 8'h00, 1'b0, 8'h00);
        chk("det_1110_hits", 32'(det_hits), 32'd2);

        step(1'b1, 8'hF0, 1'b1, 8'hF0);
        repeat (FL) step(1'b1, 8'h0F, 1'b1, 8'h0F);
        repeat (FL + 2) step(1'b0, 8'h00, 1'b0, 8'h00);

        step(1'b1, 8'h00, 1'b1, 8'h00);
        repeat (3) step(1'b0, 8'h00, 1'b0, 8'h00);
        step(1'b1, 8'hFF, 1'b1, 8'hFF);
        repeat (FL + 1) step(1'b0, 8'h00, 1'b0, 8'h00);

        step(1'b1, 8'h01, 1'b1, 8'h01);
        repeat (3) step(1'b0, 8'h00, 1'b0, 8'h00);
        rst_n = 1'b0;
        #1;
        clr_model();
        check_dut(0, b0.Dout, b0.Dvalid, b0.Ready, b0.Last, b0.Busy);
        check_dut(1, b1.Dout, b1.Dvalid, b1.Ready, b1.Last, b1.Busy);
        repeat (2) step(1'b1, 8'hA5, 1'b1, 8'hA5);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0, 8'h00);
        step(1'b1, 8'h01, 1'b1, 8'h01);
        repeat (FL + 2) step(1'b0, 8'h00, 1'b0, 8'h00);

        `ifdef SER_PARITY_EN
        step(1'b1, 8'h07, 1'b1, 8'h07);
        repeat (FL + 2) step(1'b0, 8'h00, 1'b0, 8'h00);
        `endif

        repeat (300) step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 3) != 0), 8'($urandom));
        repeat (FL + 2) step(1'b0, 8'h00, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
